tff_toggle_gen: RTL and testbench
=================================

# tff_toggle_gen

Toggle-request generator that drives the `t` input of the downstream T flip-flop. It synchronises and debounces a raw push-button, emitting exactly one single-cycle `t` pulse per accepted press. An optional free-running auto-toggle mode emits periodic pulses. It also keeps a wrap-around count of every pulse issued.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronised-high samples required to accept a press, and consecutive low samples required to accept a release. Legal range is 2..255.
- `PERIOD`, default 8: auto-mode pulse period in clocks. Legal range is 2..65535.

- `clk`  input  1  rising-edge clock; single clock domain.
- `rstn`  input  1  reset, asynchronous, active-low.
- `btn`  input  1  raw push-button level; asynchronous to `clk`; may bounce.
- `auto_en`  input  1  synchronous level that enables periodic auto-toggle pulses.
- `t`  output  1  registered toggle request; high for exactly one cycle per event; connects to the T flip-flop `t`.
- `pressed`  output  1  registered debounced button level.
- `toggle_count`  output  8  number of `t` pulses issued; wraps 255 -> 0.

## Operation
- **Reset (`rstn`=0):** all state clears immediately, regardless of clock.
  - Synchroniser flops go to 0 and the FSM goes to IDLE.
  - Debounce counter, period counter, `t`, `pressed` and `toggle_count` all go to 0.
- **Synchroniser:** two flops on `btn`. `btn_s` is `btn` delayed by two clock edges. The FSM and counters use only `btn_s`.
- **FSM states:** IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - **IDLE:**
    - `btn_s`=1 -> PRESS_WAIT, debounce count <- 1.
    - Otherwise stay.
  - **PRESS_WAIT:**
    - `btn_s`=0 -> IDLE. This is a bounce: count cleared, no pulse.
    - `btn_s`=1 and count==DEBOUNCE_CYCLES-1 -> PRESSED; press event fires; `pressed` <- 1.
    - `btn_s`=1 otherwise -> count++.
  - **PRESSED:**
    - `btn_s`=0 -> RELEASE_WAIT, count <- 1.
    - Otherwise stay; a held button never re-fires.
  - **RELEASE_WAIT:**
    - `btn_s`=1 -> PRESSED. This is a bounce: no event, `pressed` stays 1.
    - `btn_s`=0 and count==DEBOUNCE_CYCLES-1 -> IDLE, `pressed` <- 0.
    - `btn_s`=0 otherwise -> count++.
- **Auto mode:**
  - While `auto_en`=0, the period counter is held at 0.
  - On each edge with `auto_en`=1:
    - If the period counter == PERIOD-1: counter <- 0 and an auto event fires.
    - Otherwise: counter++.
  - Deasserting `auto_en` mid-period discards the partial count.
- **Output:**
  - `t` <- (press event OR auto event).
  - Coincident events produce one pulse, not two, and `toggle_count` increments by 1.
  - `toggle_count` increments on every edge that sets `t`=1, modulo 256.
- **Reset release with `btn` held high:** the press is debounced from IDLE as a new press and produces one pulse.

## Timing
- **Press latency:**
  - `btn` rises before edge B; `btn_s` is first sampled high by the FSM at edge B+2.
  - `t`=1 after edge B+1+DEBOUNCE_CYCLES and drops at the next edge.
  - With D=4, `t` is high between edges B+5 and B+6.
  - `pressed` rises on the same edge as `t`.
- **Release latency:**
  - `btn` falls before edge R.
  - `pressed`=0 after edge R+1+DEBOUNCE_CYCLES.
- **Bounce rejection:** any low `btn_s` sample inside PRESS_WAIT restarts the qualification. At least DEBOUNCE_CYCLES fresh consecutive highs are required.
- **Auto latency:**
  - The first edge sampling `auto_en`=1 is A.
  - Pulses follow edge A+PERIOD-1, then every PERIOD edges.
  - With P=8, pulses follow edges A+7, A+15, A+23, and so on.
- **Pulse spacing:** `t` is never high for two consecutive cycles from a single source. Adjacent press and auto events on different edges give two separate pulses.
- **Async reset mid-pulse:** `t` drops immediately; no pulse follows reset release unless it is re-qualified.

## Test plan
- **Reset:** hold `rstn`=0 with `btn`=1 and `auto_en`=1, clocks running -> `t`=0, `pressed`=0, `toggle_count`=0 throughout. Release reset -> exactly one `t` pulse, at edge 2+DEBOUNCE_CYCLES-1 after release, and no auto pulse before 7 edges.
- **Clean press (D=4):** raise `btn` before edge 10 and hold for 20 cycles -> `t` high only between edges 15 and 16, `pressed`=1 from edge 15, `toggle_count`=1. Drop `btn` before edge 30 -> `pressed`=0 after edge 35, no extra pulse.
- **Bounce:** `btn` high for 2 cycles, low for 1, then high and held -> no pulse from the first burst; single pulse 5 edges after the final rise; `toggle_count`=1. Low glitch of 2 cycles while pressed -> `pressed` stays 1, no pulse.
- **Auto mode (P=8):** `auto_en`=1 from edge A for 40 cycles -> pulses after A+7, A+15, A+23, A+31, A+39; `toggle_count`=5. Drop `auto_en` at A+20 and re-raise at A+25 -> next pulse after A+32.
- **Coincidence:** align a qualified press with an auto event on the same edge -> one pulse, `toggle_count` +1.
- **Wrap:** issue 257 pulses via auto mode -> `toggle_count` reads 255 then 0 then 1; `t` timing is unchanged.

Source files
------------

// File: rtl/tff_toggle_gen.sv
// tff_toggle_gen: turns a raw, bouncing push-button into one single-cycle
// toggle request per accepted press. It can also generate periodic
// auto-toggle requests, and it counts every request it issues (mod 256).
module tff_toggle_gen #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PERIOD          = 8
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       btn,
  input  logic       auto_en,
  output logic       t,
  output logic       pressed,
  output logic [7:0] toggle_count
);

  // Terminal values are pre-sized to the counter widths so the compares match.
  localparam logic [7:0]  DB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] PER_LAST = 16'(PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  state_t      state;
  logic [1:0]  sync_q;
  logic        btn_s;
  logic [7:0]  db_cnt;
  logic [15:0] per_cnt;
  logic        press_evt;
  logic        auto_evt;

  assign btn_s = sync_q[1];

  // Two-flop synchroniser; nothing downstream ever looks at raw btn.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sync_q <= 2'b00;
    else       sync_q <= {sync_q[0], btn};
  end

  // A press is accepted on the edge that sees the last qualifying high
  // sample. The FSM uses the same condition when it moves to PRESSED.
  always_comb begin
    press_evt = (state == PRESS_WAIT) && btn_s && (db_cnt == DB_LAST);
    auto_evt  = auto_en && (per_cnt == PER_LAST);
  end

  // Debounce FSM. db_cnt counts consecutive samples that agree with the
  // pending transition. Any disagreeing sample abandons that transition.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      db_cnt  <= '0;
      pressed <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (btn_s) begin
            state  <= PRESS_WAIT;
            db_cnt <= 8'd1;
          end
        end
        PRESS_WAIT: begin
          if (!btn_s) begin
            state  <= IDLE;
            db_cnt <= '0;
          end else if (db_cnt == DB_LAST) begin
            state   <= PRESSED;
            db_cnt  <= '0;
            pressed <= 1'b1;
          end else begin
            db_cnt <= db_cnt + 8'd1;
          end
        end
        PRESSED: begin
          // A held button stays here and never re-fires.
          if (!btn_s) begin
            state  <= RELEASE_WAIT;
            db_cnt <= 8'd1;
          end
        end
        RELEASE_WAIT: begin
          if (btn_s) begin
            // This was a low glitch while held. Go back quietly.
            state  <= PRESSED;
            db_cnt <= '0;
          end else if (db_cnt == DB_LAST) begin
            state   <= IDLE;
            db_cnt  <= '0;
            pressed <= 1'b0;
          end else begin
            db_cnt <= db_cnt + 8'd1;
          end
        end
        default: begin
          state  <= IDLE;
          db_cnt <= '0;
        end
      endcase
    end
  end

  // Auto-mode period counter. Dropping auto_en discards any partial period.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                  per_cnt <= '0;
    else if (!auto_en)          per_cnt <= '0;
    else if (per_cnt == PER_LAST) per_cnt <= '0;
    else                        per_cnt <= per_cnt + 16'd1;
  end

  // Press and auto events merge into one pulse, which is counted once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      t            <= 1'b0;
      toggle_count <= '0;
    end else begin
      t <= press_evt | auto_evt;
      if (press_evt | auto_evt) toggle_count <= toggle_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_tff_toggle_gen.sv
// Bench for tff_toggle_gen: directed scenarios plus random traffic. The
// outputs are checked on every clock against a behavioural model.
module tb_tff_toggle_gen;
  localparam int D = 4;
  localparam int P = 8;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       btn = 1'b0;
  logic       auto_en = 1'b0;
  logic       t;
  logic       pressed;
  logic [7:0] toggle_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state.
  logic       dly_q[$];   // btn as seen through two clock edges of delay
  int         m_run;      // consecutive samples disagreeing with m_pressed
  logic       m_pressed;
  int         m_arun;     // consecutive edges with auto_en high
  logic       m_t;
  int         m_cnt;

  tff_toggle_gen #(.DEBOUNCE_CYCLES(D), .PERIOD(P)) dut (
    .clk(clk), .rstn(rstn), .btn(btn), .auto_en(auto_en),
    .t(t), .pressed(pressed), .toggle_count(toggle_count)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    dly_q = '{1'b0, 1'b0};
    m_run = 0; m_pressed = 1'b0; m_arun = 0; m_t = 1'b0; m_cnt = 0;
  endtask

  // One clock edge as seen by the specification's rules.
  task automatic model_edge(input logic b, input logic a);
    logic bs;
    logic pe;
    logic ae;
    bs = dly_q.pop_front();
    dly_q.push_back(b);
    pe = 1'b0;
    if (bs != m_pressed) begin
      m_run++;
      if (m_run == D) begin
        m_pressed = ~m_pressed;
        m_run = 0;
        pe = m_pressed;
      end
    end else begin
      m_run = 0;
    end
    if (a) begin
      m_arun++;
      ae = (m_arun % P) == 0;
    end else begin
      m_arun = 0;
      ae = 1'b0;
    end
    m_t = pe | ae;
    m_cnt = (m_cnt + (m_t ? 1 : 0)) % 256;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".t"}, {7'd0, t}, {7'd0, m_t});
    chk({tag, ".pressed"}, {7'd0, pressed}, {7'd0, m_pressed});
    chk({tag, ".count"}, toggle_count, 8'(m_cnt));
  endtask

  // Drive the inputs for one cycle, take the edge, then check just after it.
  task automatic cyc(input logic b, input logic a, input string tag);
    btn = b;
    auto_en = a;
    @(posedge clk);
    if (rstn) model_edge(b, a);
    #1;
    chk_all(tag);
  endtask

  // Reset pulse asserted mid-cycle. Outputs must clear without a clock.
  task automatic async_reset(input string tag);
    rstn = 1'b0;
    #1;
    model_reset();
    chk_all(tag);
    #1 rstn = 1'b1;
  endtask

  initial begin
    int pulse_at;
    int fall_at;
    int got;
    logic rb;
    logic ra;

    model_reset();

    // Reset is held with btn and auto_en high and the clock running.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, "reset_hold");
    rstn = 1'b1;
    for (int i = 0; i < 12; i++) cyc(1'b1, 1'b1, "reset_release");

    // Clean press: the pulse comes 5 edges after the first edge that sees btn.
    async_reset("rst_clean");
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, "idle");
    pulse_at = -1;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b0, "clean_press");
      if (t === 1'b1 && pulse_at < 0) pulse_at = i;
    end
    chk("clean_press_edge", 8'(pulse_at), 8'd5);
    chk("clean_press_count", toggle_count, 8'd1);
    fall_at = -1;
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, 1'b0, "clean_release");
      if (pressed === 1'b0 && fall_at < 0) fall_at = i;
    end
    chk("clean_release_edge", 8'(fall_at), 8'd5);
    chk("clean_release_count", toggle_count, 8'd1);

    // Bounce on press, then a 2-cycle low glitch while held.
    async_reset("rst_bounce");
    cyc(1'b1, 1'b0, "bounce"); cyc(1'b1, 1'b0, "bounce"); cyc(1'b0, 1'b0, "bounce");
    for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, "bounce_hold");
    chk("bounce_count", toggle_count, 8'd1);
    cyc(1'b0, 1'b0, "glitch"); cyc(1'b0, 1'b0, "glitch");
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, "glitch_hold");
    chk("glitch_pressed", {7'd0, pressed}, 8'd1);
    chk("glitch_count", toggle_count, 8'd1);

    // Auto mode: 40 cycles, then drop it for a while mid-period.
    async_reset("rst_auto");
    for (int i = 0; i < 40; i++) cyc(1'b0, 1'b1, "auto");
    chk("auto_count", toggle_count, 8'd5);
    async_reset("rst_auto2");
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, "auto_gap_a");
    for (int i = 0; i < 5; i++)  cyc(1'b0, 1'b0, "auto_gap_off");
    pulse_at = -1;
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, 1'b1, "auto_gap_b");
      if (t === 1'b1 && pulse_at < 0) pulse_at = i;
    end
    chk("auto_regap_edge", 8'(pulse_at), 8'd7);

    // Coincidence: press qualified on the same edge as an auto event.
    async_reset("rst_coin");
    cyc(1'b0, 1'b1, "coin_a"); cyc(1'b0, 1'b1, "coin_a");
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, "coin");
    chk("coin_count", toggle_count, 8'd1);

    // Wrap: 257 auto pulses bring the count back round to 1.
    async_reset("rst_wrap");
    for (int i = 0; i < 257 * P; i++) cyc(1'b0, 1'b1, "wrap");
    chk("wrap_count", toggle_count, 8'd1);

    // Async reset while t is high. The wait for the pulse is bounded.
    async_reset("rst_mid");
    got = 0;
    for (int i = 0; i < 4 * P && got == 0; i++) begin
      cyc(1'b0, 1'b1, "mid_wait");
      if (m_t) got = 1;
    end
    chk("mid_pulse_seen", 8'(got), 8'd1);
    async_reset("mid_pulse_reset");
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, "mid_after");

    // Random traffic: sticky btn and auto_en, with occasional resets.
    rb = 1'b0; ra = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(3, 0) == 0)  rb = ~rb;
      if ($urandom_range(15, 0) == 0) ra = ~ra;
      cyc(rb, ra, "random");
      if ($urandom_range(199, 0) == 0) async_reset("random_rst");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
